// File: rtl/svm_pkg.sv
// Shared constants and FSM encoding for the SVM window sequencer.
package svm_pkg;

  // Default window and block-map geometry, in HOG blocks
  localparam int WIN_W    = 7;
  localparam int WIN_H    = 15;
  localparam int BLK_COLS = 79;
  localparam int BLK_ROWS = 59;
  localparam int COE_N    = WIN_W * WIN_H;

  // Partial products and bias are Q4.28
  localparam int Q_INT_W  = 4;
  localparam int Q_FRAC_W = 28;
  localparam int SCORE_W  = Q_INT_W + Q_FRAC_W;
  // 7 guard bits cover 105 terms plus the bias
  localparam int ACC_W    = SCORE_W + 7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_DRAIN  = 3'd2,
    S_RESULT = 3'd3,
    S_DONE   = 3'd4
  } svm_state_e;

endpackage

// File: rtl/svm_valid_dly.sv
// Valid delay line of fixed depth; empty is high when no bit is in flight.
module svm_valid_dly #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic vld_i,
  output logic vld_o,
  output logic empty_o
);

  logic [DEPTH-1:0] vld_pipe_q;

  // Shift the valid bit one stage per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= vld_i;
      for (int i = 1; i < DEPTH; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  assign vld_o   = vld_pipe_q[DEPTH-1];
  assign empty_o = ~|vld_pipe_q;

endmodule

// File: rtl/svm_ctrl.sv
// Scans every window position of the HOG block map through one shared svm_pe,
// accumulates per-block partials, adds the bias and hands out one result per window.
module svm_ctrl
  import svm_pkg::*;
#(
  parameter int WIN_W    = svm_pkg::WIN_W,
  parameter int WIN_H    = svm_pkg::WIN_H,
  parameter int BLK_COLS = svm_pkg::BLK_COLS,
  parameter int BLK_ROWS = svm_pkg::BLK_ROWS,
  parameter int BID_W    = 13,
  parameter int CID_W    = 7,
  parameter int MEM_LAT  = 1,
  parameter int PE_LAT   = 3,
  parameter int SCORE_W  = svm_pkg::SCORE_W,
  parameter int ACC_W    = SCORE_W + 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      fea_rd,
  output logic [BID_W-1:0]          fea_addr,
  output logic [CID_W-1:0]          coef_addr,
  output logic                      pe_valid,
  input  logic signed [SCORE_W-1:0] pe_data,
  input  logic signed [SCORE_W-1:0] bias,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [7:0]                res_win_x,
  output logic [7:0]                res_win_y,
  output logic signed [ACC_W-1:0]   res_score,
  output logic                      res_hit
);

  localparam int BX_W = $clog2(WIN_W + 1);
  localparam int BY_W = $clog2(WIN_H + 1);
  localparam logic [BX_W-1:0] BX_LAST = BX_W'(WIN_W - 1);
  localparam logic [BY_W-1:0] BY_LAST = BY_W'(WIN_H - 1);
  localparam logic [7:0]      WX_LAST = 8'(BLK_COLS - WIN_W);
  localparam logic [7:0]      WY_LAST = 8'(BLK_ROWS - WIN_H);

  svm_state_e state_q, state_d;
  logic [7:0]      wx_q, wx_d, wy_q, wy_d;
  logic [BX_W-1:0] bx_q, bx_d;
  logic [BY_W-1:0] by_q, by_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, bias_q, bias_d, score_q, score_d;
  logic signed [ACC_W-1:0] pe_ext, bias_ext;
  logic pv_empty, acc_en, ae_empty;

  assign pe_ext   = {{(ACC_W-SCORE_W){pe_data[SCORE_W-1]}}, pe_data};
  assign bias_ext = {{(ACC_W-SCORE_W){bias[SCORE_W-1]}}, bias};

  // Read issue -> PE input valid (memory latency)
  svm_valid_dly #(.DEPTH(MEM_LAT)) u_mem_dly (
    .clk(clk), .rst(rst), .vld_i(fea_rd), .vld_o(pe_valid), .empty_o(pv_empty)
  );

  // PE input valid -> partial ready to accumulate (PE latency)
  svm_valid_dly #(.DEPTH(PE_LAT)) u_pe_dly (
    .clk(clk), .rst(rst), .vld_i(pe_valid), .vld_o(acc_en), .empty_o(ae_empty)
  );

  // State, counters, bias and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wx_q    <= '0;
      wy_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      acc_q   <= '0;
      bias_q  <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      acc_q   <= acc_d;
      bias_q  <= bias_d;
      score_q <= score_d;
    end
  end

  // Next-state: window/block walk, accumulation and result capture
  always_comb begin
    state_d = state_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    bx_d    = bx_q;
    by_d    = by_q;
    bias_d  = bias_q;
    score_d = score_q;
    acc_d   = acc_en ? acc_q + pe_ext : acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bias_d  = bias_ext;
          wx_d    = '0;
          wy_d    = '0;
          bx_d    = '0;
          by_d    = '0;
          acc_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bx_q == BX_LAST) begin
          bx_d = '0;
          if (by_q == BY_LAST) begin
            by_d    = '0;
            state_d = S_DRAIN;
          end else begin
            by_d = by_q + 1'b1;
          end
        end else begin
          bx_d = bx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Both lines empty means the last partial has landed in acc
        if (pv_empty && ae_empty) begin
          score_d = acc_q + bias_q;
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (res_ready) begin
          acc_d   = '0;
          state_d = S_ISSUE;
          if (wx_q == WX_LAST) begin
            wx_d = '0;
            if (wy_q == WY_LAST) state_d = S_DONE;
            else                 wy_d    = wy_q + 8'd1;
          end else begin
            wx_d = wx_q + 8'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign fea_rd    = (state_q == S_ISSUE);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_RESULT);
  assign done      = (state_q == S_DONE);
  assign res_valid = (state_q == S_RESULT);

  // Addresses are held at zero outside ISSUE so idle outputs stay quiet
  assign fea_addr  = fea_rd ? (BID_W'(wy_q) + BID_W'(by_q)) * BID_W'(BLK_COLS)
                              + BID_W'(wx_q) + BID_W'(bx_q) : '0;
  assign coef_addr = fea_rd ? CID_W'(by_q) * CID_W'(WIN_W) + CID_W'(bx_q) : '0;

  assign res_win_x = res_valid ? wx_q : '0;
  assign res_win_y = res_valid ? wy_q : '0;
  assign res_score = score_q;
  assign res_hit   = (score_q > 0);

endmodule

// File: tb/tb_svm_ctrl.sv
// Scoreboard bench for svm_ctrl: small map for sequencing/handshake, default map for range.
module tb_svm_ctrl;

  localparam int WW = 2, WH = 2, BC = 4, BR = 3, ML = 1, PL = 3;
  localparam int BW = 13, CW = 7, SW = 32, AW = 39;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, busy, done, fea_rd, pe_valid, res_valid, res_ready, res_hit;
  logic [BW-1:0] fea_addr;
  logic [CW-1:0] coef_addr;
  logic signed [SW-1:0] pe_data, bias;
  logic [7:0] res_win_x, res_win_y;
  logic signed [AW-1:0] res_score;

  logic start2, busy2, done2, fea_rd2, pe_valid2, res_valid2, res_ready2, res_hit2;
  logic [BW-1:0] fea_addr2;
  logic [CW-1:0] coef_addr2;
  logic signed [SW-1:0] pe_data2, bias2;
  logic [7:0] res_win_x2, res_win_y2;
  logic signed [AW-1:0] res_score2;

  svm_ctrl #(
    .WIN_W(WW), .WIN_H(WH), .BLK_COLS(BC), .BLK_ROWS(BR), .BID_W(BW), .CID_W(CW),
    .MEM_LAT(ML), .PE_LAT(PL), .SCORE_W(SW), .ACC_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fea_rd(fea_rd), .fea_addr(fea_addr), .coef_addr(coef_addr), .pe_valid(pe_valid),
    .pe_data(pe_data), .bias(bias), .res_valid(res_valid), .res_ready(res_ready),
    .res_win_x(res_win_x), .res_win_y(res_win_y), .res_score(res_score), .res_hit(res_hit)
  );

  svm_ctrl dut_full (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .fea_rd(fea_rd2), .fea_addr(fea_addr2), .coef_addr(coef_addr2), .pe_valid(pe_valid2),
    .pe_data(pe_data2), .bias(bias2), .res_valid(res_valid2), .res_ready(res_ready2),
    .res_win_x(res_win_x2), .res_win_y(res_win_y2), .res_score(res_score2), .res_hit(res_hit2)
  );

  typedef struct { int x; int y; longint score; bit hit; } res_t;
  res_t sbq[$];
  int   rdq[$];
  int   cfq[$];
  res_t e;
  int   n_chk = 0, n_fail = 0, n_res = 0, done_cnt = 0;
  longint cyc = 0, t0;
  logic fr_d;

  always @(posedge clk) cyc <= cyc + 1;

  // PE model: returns the block id that was read MEM_LAT+PE_LAT cycles ago
  logic [ML+PL-1:0][BW-1:0] pp = '0;
  always @(posedge clk) pp <= {pp[ML+PL-2:0], fea_addr};
  assign pe_data = SW'(pp[ML+PL-1]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {busy, done, fea_rd, pe_valid, res_valid, res_hit,
              fea_addr, coef_addr, res_win_x, res_win_y}, 64'd0);
    chk({tag, "_score"}, res_score, 64'd0);
  endtask

  // Expected reads and results for a whole scan of the small map
  task automatic push_scan(input longint b);
    for (int wy = 0; wy <= BR - WH; wy++)
      for (int wx = 0; wx <= BC - WW; wx++) begin
        longint s = b;
        for (int by = 0; by < WH; by++)
          for (int bx = 0; bx < WW; bx++) begin
            int a = (wy + by) * BC + wx + bx;
            rdq.push_back(a);
            cfq.push_back(by * WW + bx);
            s += a;
          end
        sbq.push_back('{wx, wy, s, s > 0});
      end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Monitor: reads, pe_valid alignment, result handshakes, done
  always @(negedge clk) begin
    if (rst) begin
      fr_d <= 1'b0;
    end else begin
      chk("pe_valid", pe_valid, fr_d);
      fr_d <= fea_rd;
      if (fea_rd) begin
        if (rdq.size() == 0) chk("rd_extra", 1, 0);
        else begin
          chk("fea_addr", fea_addr, rdq.pop_front());
          chk("coef_addr", coef_addr, cfq.pop_front());
        end
      end
      if (res_valid && res_ready) begin
        n_res++;
        if (sbq.size() == 0) chk("res_extra", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("res_x", res_win_x, e.x);
          chk("res_y", res_win_y, e.y);
          chk("res_score", res_score, e.score);
          chk("res_hit", res_hit, e.hit);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last", sbq.size(), 0);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; res_ready = 1'b0; bias = '0;
    start2 = 1'b0; res_ready2 = 1'b0; bias2 = '0; pe_data2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Full scan, first result stalled for 50 cycles, stray start mid-scan
    bias = -20;
    push_scan(-20);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; bias = 32'sd99;
    t0 = cyc;
    chk("busy_issue", busy, 1);
    for (int i = 0; i < 100 && !res_valid; i++) @(negedge clk);
    chk("first_latency", cyc - t0, 9);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("stall_valid", {res_valid, fea_rd, busy}, 3'b101);
      chk("stall_x", res_win_x, sbq[0].x);
      chk("stall_y", res_win_y, sbq[0].y);
      chk("stall_score", res_score, sbq[0].score);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    repeat (3) @(posedge clk);
    pulse_start();
    for (int i = 0; i < 400 && done_cnt < 1; i++) @(negedge clk);
    chk("done_cnt1", done_cnt, 1);
    chk("res_cnt1", n_res, 6);
    chk("rd_left1", rdq.size(), 0);
    @(negedge clk);
    chk("busy_after_done", {busy, done}, 2'b00);

    // Abort during ISSUE of window 3, then restart from (0,0)
    n_res = 0;
    push_scan(-20);
    bias = -20;
    pulse_start();
    for (int i = 0; i < 200 && n_res < 3; i++) @(negedge clk);
    chk("reach_win3", n_res, 3);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 sbq.delete(); rdq.delete(); cfq.delete(); n_res = 0;
    @(negedge clk);
    chk_idle("abort");
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    chk("no_done_abort", done_cnt, 1);
    chk("no_res_abort", n_res, 0);

    bias = 7;
    push_scan(7);
    pulse_start();
    bias = -99;
    for (int i = 0; i < 600 && done_cnt < 2; i++) @(negedge clk);
    chk("done_cnt2", done_cnt, 2);
    chk("res_cnt2", n_res, 6);
    chk("sb_left2", sbq.size(), 0);

    // Default geometry: 105 most-negative partials must not wrap
    bias2 = -1;
    pe_data2 = 32'sh8000_0000;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 0; i < 400 && !res_valid2; i++) @(negedge clk);
    chk("full_valid", res_valid2, 1);
    chk("full_score", res_score2, -64'sd105 * 64'sd2147483648 - 64'sd1);
    chk("full_hit", res_hit2, 0);
    chk("full_win", {res_win_x2, res_win_y2}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
